// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and line idle level.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path; power-of-two depth, pointers wrap modulo depth.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) with a transmit FIFO.
// All outputs are registered one cycle behind the frame state machine.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Tx_DV,
    input  logic [UART_DATA_BITS-1:0] i_Tx_Byte,
    output logic                      o_Tx_Ready,
    output logic                      o_Tx_Serial,
    output logic                      o_Tx_Active,
    output logic                      o_Tx_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST     = IW'(UART_DATA_BITS - 1);
    localparam logic [FW:0]   ALMOST_COUNT = (FW+1)'(FIFO_DEPTH - 1);

    uart_tx_state_t            r_state;
    logic [CW-1:0]             r_clk_cnt;
    logic [IW-1:0]             r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_Tx_Ready;
    logic                      r_Tx_Serial;
    logic                      r_Tx_Active;
    logic                      r_Tx_Done;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_bit_end;
    logic                      w_full_next;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [FW:0]               w_fifo_count;
    logic [UART_DATA_BITS-1:0] w_fifo_data;
    logic                      w_serial;
    logic                      w_active;
    logic                      w_done;

    assign w_push    = i_Tx_DV && r_Tx_Ready;
    assign w_bit_end = (r_clk_cnt == CNT_LAST);
    assign w_pop     = !w_fifo_empty && ((r_state == IDLE) || (r_state == STOP && w_bit_end));

    // Ready is registered, so it must be computed from the occupancy this edge will produce.
    assign w_full_next = !w_pop && (w_fifo_full || (w_fifo_count == ALMOST_COUNT && w_push));

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_Tx_Byte),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
        end else begin
            if (w_pop) r_data <= w_fifo_data;
            if (r_state != IDLE) r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CW'(1);
            case (r_state)
                IDLE:  if (!w_fifo_empty) r_state <= START;
                START: if (w_bit_end) begin
                    r_state   <= DATA;
                    r_bit_idx <= '0;
                end
                DATA:  if (w_bit_end) begin
                    if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= STOP;
`endif
                    end else begin
                        r_bit_idx <= r_bit_idx + IW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_bit_end) r_state <= STOP;
`endif
                STOP:  if (w_bit_end) r_state <= w_fifo_empty ? IDLE : START;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_serial = UART_IDLE_LEVEL;
        w_active = 1'b1;
        w_done   = 1'b0;
        case (r_state)
            START:  w_serial = ~UART_IDLE_LEVEL;
            DATA:   w_serial = r_data[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY: w_serial = ^r_data;
`endif
            STOP:   w_done   = w_bit_end;
            default: w_active = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Tx_Ready  <= 1'b1;
            r_Tx_Serial <= UART_IDLE_LEVEL;
            r_Tx_Active <= 1'b0;
            r_Tx_Done   <= 1'b0;
        end else begin
            r_Tx_Ready  <= !w_full_next;
            r_Tx_Serial <= w_serial;
            r_Tx_Active <= w_active;
            r_Tx_Done   <= w_done;
        end
    end

    assign o_Tx_Ready  = r_Tx_Ready;
    assign o_Tx_Serial = r_Tx_Serial;
    assign o_Tx_Active = r_Tx_Active;
    assign o_Tx_Done   = r_Tx_Done;

endmodule
